// File: rtl/mem_stage_bram.sv
// MEM stage with synchronous-read (BRAM-style) data memory split into byte lanes,
// byte/half/word loads and stores, WB store-data forwarding and a one-stall load FSM.

module mem_stage_bram_lane #(
  parameter int ADDR_W = 10,
  parameter int VEC_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [VEC_W-1:0]  wd,
  output logic [VEC_W-1:0]  rd
);
  logic [VEC_W-1:0] ram [2**ADDR_W];

  // No reset on the array or the read register so the lane maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) ram[idx] <= wd;
    if (re) rd <= ram[idx];
  end
endmodule

module mem_stage_bram #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] busB,
  input  logic        ForwardD,
  input  logic [31:0] C4,
  output logic        stall,
  output logic        rdata_valid,
  output logic [31:0] dm_rdata,
  output logic        misalign
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
  } ld_req_t;

  state_t  state;
  ld_req_t ld_q;
  logic [31:0] dm_q, wd, ext;
  logic [ADDR_W-1:0] idx;
  logic is_word, is_half, aligned, req, do_st, do_ld;
  logic [NUM_LANES-1:0] be;
  logic [NUM_LANES-1:0][VEC_W-1:0] wd_lane, rd_word;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];
  assign idx     = addr[ADDR_W+1:2];
  assign wd      = ForwardD ? C4 : busB;
  assign is_word = size[1];
  assign is_half = (size == 2'b01);
  assign aligned = is_word ? (addr[1:0] == 2'b00) : (is_half ? !addr[0] : 1'b1);

  assign req      = in_valid & (mem_read | mem_write) & (state == IDLE);
  assign misalign = req & !aligned;
  assign do_st    = req & mem_write & aligned & !rst;
  assign do_ld    = req & mem_read & !mem_write & aligned & !rst;
  assign stall    = do_ld;

  // Replicate narrow store data so every lane sees its slice at the same bit position.
  assign wd_lane = is_word ? wd : (is_half ? {2{wd[15:0]}} : {4{wd[7:0]}});

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LN = 2'(l);
    assign be[l] = do_st & (is_word | (is_half & (addr[1] == LN[1])) |
                            (!is_word & !is_half & (addr[1:0] == LN)));
    mem_stage_bram_lane #(.ADDR_W(ADDR_W), .VEC_W(VEC_W)) u_lane (
      .clk (clk),
      .we  (be[l]),
      .re  (do_ld),
      .idx (idx),
      .wd  (wd_lane[l]),
      .rd  (rd_word[l])
    );
  end

  assign b_sel = rd_word[ld_q.off];
  assign h_sel = ld_q.off[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};

  always_comb begin
    ext = rd_word;
    case (ld_q.size)
      2'b00:   ext = {{24{!ld_q.uns & b_sel[7]}}, b_sel};
      2'b01:   ext = {{16{!ld_q.uns & h_sel[15]}}, h_sel};
      default: ext = rd_word;
    endcase
  end

  assign rdata_valid = (state == RD_WAIT);
  assign dm_rdata    = rdata_valid ? ext : dm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dm_q  <= '0;
    end else begin
      case (state)
        IDLE: if (do_ld) begin
          state <= RD_WAIT;
          ld_q  <= '{off: addr[1:0], size: size, uns: load_unsigned};
        end
        RD_WAIT: begin
          state <= IDLE;
          dm_q  <= ext;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_bram.sv
// Bench for mem_stage_bram: a 1K-word and a 16-word instance share stimulus; a byte-level
// memory model checks both every cycle, and directed loads pin literal results.

module tb_mem_stage_bram;
  logic clk = 1'b0;
  logic rst, in_valid, mem_read, mem_write, load_unsigned, ForwardD;
  logic [1:0]  size;
  logic [31:0] addr, busB, C4;
  logic        stall_o [2];
  logic        rv_o    [2];
  logic        mis_o   [2];
  logic [31:0] dm_o    [2];

  int n_cmp = 0;
  int n_fail = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  mem_stage_bram #(.ADDR_W(10)) u_big (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned), .addr(addr), .busB(busB), .ForwardD(ForwardD),
    .C4(C4), .stall(stall_o[0]), .rdata_valid(rv_o[0]), .dm_rdata(dm_o[0]), .misalign(mis_o[0]));

  mem_stage_bram #(.ADDR_W(4)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned), .addr(addr), .busB(busB), .ForwardD(ForwardD),
    .C4(C4), .stall(stall_o[1]), .rdata_valid(rv_o[1]), .dm_rdata(dm_o[1]), .misalign(mis_o[1]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: byte-addressed memory ----------------
  logic [7:0]  mb [int];
  bit          busy [2];
  logic [31:0] pend [2];
  logic [31:0] last [2];

  function automatic int key(int k, logic [31:0] a);
    return k * 65536 + int'(a & (k == 1 ? 32'h3F : 32'hFFF));
  endfunction

  function automatic logic [7:0] rdb(int k, logic [31:0] a);
    if (mb.exists(key(k, a))) return mb[key(k, a)];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] mload(int k, logic [31:0] a, logic [1:0] sz, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] base;
    if (sz == 2'b00) begin
      b = rdb(k, a);
      return uns ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (sz == 2'b01) begin
      h = {rdb(k, a + 1), rdb(k, a)};
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    base = a & ~32'h3;
    return {rdb(k, base + 3), rdb(k, base + 2), rdb(k, base + 1), rdb(k, base)};
  endfunction

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        logic al, e_mis, e_stall;
        logic [31:0] e_dm, wdat;
        al = (size == 2'b00) || (size == 2'b01 && !addr[0]) || (size[1] && addr[1:0] == 2'b00);
        e_mis   = in_valid && (mem_read || mem_write) && !al && !busy[k];
        e_stall = !rst && !busy[k] && in_valid && mem_read && !mem_write && al;
        e_dm    = busy[k] ? pend[k] : last[k];
        chk("misalign", k, {31'h0, mis_o[k]}, {31'h0, e_mis});
        chk("stall", k, {31'h0, stall_o[k]}, {31'h0, e_stall});
        chk("rdata_valid", k, {31'h0, rv_o[k]}, {31'h0, busy[k]});
        if (!$isunknown(e_dm)) chk("dm_rdata", k, dm_o[k], e_dm);
        if (rst) begin
          busy[k] = 1'b0;
          last[k] = 32'h0;
        end else if (busy[k]) begin
          busy[k] = 1'b0;
          last[k] = pend[k];
        end else if (in_valid && al && mem_write) begin
          wdat = ForwardD ? C4 : busB;
          if (size == 2'b00) mb[key(k, addr)] = wdat[7:0];
          else if (size == 2'b01) begin
            mb[key(k, addr)] = wdat[7:0];
            mb[key(k, addr + 1)] = wdat[15:8];
          end else
            for (int i = 0; i < 4; i++) mb[key(k, addr + i)] = wdat[8*i +: 8];
        end else if (in_valid && al && mem_read) begin
          busy[k] = 1'b1;
          pend[k] = mload(k, addr, size, load_unsigned);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    in_valid = 0; mem_read = 0; mem_write = 0; ForwardD = 0;
    size = 2'b10; load_unsigned = 0; addr = '0; busB = '0; C4 = '0;
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    in_valid = 1; mem_write = 1; mem_read = 0; size = sz; addr = a; busB = d;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                    input logic [31:0] e0, input logic [31:0] e1);
    in_valid = 1; mem_read = 1; mem_write = 0; size = sz; addr = a; load_unsigned = uns;
    @(negedge clk);
    chk("lit_stall", 0, {31'h0, stall_o[0]}, 32'h1);
    chk("lit_stall", 1, {31'h0, stall_o[1]}, 32'h1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("lit_rv", 0, {31'h0, rv_o[0]}, 32'h1);
    chk("lit_dm", 0, dm_o[0], e0);
    chk("lit_dm", 1, dm_o[1], e1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    run = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_stall", k, {31'h0, stall_o[k]}, 32'h0);
      chk("rst_rv", k, {31'h0, rv_o[k]}, 32'h0);
      chk("rst_dm", k, dm_o[k], 32'h0);
    end
    @(posedge clk); #1;
    rst = 0;

    // word round trip
    st(32'h10, 2'b10, 32'hDEADBEEF);
    ld(32'h10, 2'b10, 0, 32'hDEADBEEF, 32'hDEADBEEF);

    // byte lanes and extension
    st(32'h20, 2'b10, 32'h0);
    st(32'h20, 2'b00, 32'h11);
    st(32'h21, 2'b00, 32'h22);
    st(32'h22, 2'b00, 32'h80);
    st(32'h23, 2'b00, 32'h44);
    ld(32'h20, 2'b10, 0, 32'h44802211, 32'h44802211);
    ld(32'h22, 2'b00, 0, 32'hFFFFFF80, 32'hFFFFFF80);
    ld(32'h22, 2'b00, 1, 32'h00000080, 32'h00000080);
    ld(32'h22, 2'b01, 0, 32'h00004480, 32'h00004480);

    // halfword store and sign extension
    st(32'h24, 2'b10, 32'h0);
    st(32'h26, 2'b01, 32'hAAAA8001);
    ld(32'h26, 2'b01, 0, 32'hFFFF8001, 32'hFFFF8001);
    ld(32'h26, 2'b01, 1, 32'h00008001, 32'h00008001);
    ld(32'h24, 2'b11, 0, 32'h80010000, 32'h80010000);

    // forwarding from WB
    in_valid = 1; mem_write = 1; size = 2'b10; addr = 32'h0; busB = 32'h1;
    ForwardD = 1; C4 = 32'hCAFEF00D;
    @(posedge clk); #1;
    idle();
    ld(32'h0, 2'b10, 0, 32'hCAFEF00D, 32'hCAFEF00D);

    // misalignment
    st(32'h30, 2'b10, 32'h12345678);
    in_valid = 1; mem_read = 1; size = 2'b01; addr = 32'h31;
    @(negedge clk);
    chk("lit_mis_lh", 0, {31'h0, mis_o[0]}, 32'h1);
    chk("lit_mis_stall", 0, {31'h0, stall_o[0]}, 32'h0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("lit_mis_rv", 0, {31'h0, rv_o[0]}, 32'h0);
    @(posedge clk); #1;
    in_valid = 1; mem_write = 1; size = 2'b10; addr = 32'h32; busB = 32'hFFFFFFFF;
    @(negedge clk);
    chk("lit_mis_sw", 0, {31'h0, mis_o[0]}, 32'h1);
    @(posedge clk); #1;
    idle();
    ld(32'h30, 2'b10, 0, 32'h12345678, 32'h12345678);

    // read+write together: store wins, no stall
    in_valid = 1; mem_write = 1; mem_read = 1; size = 2'b10; addr = 32'h34; busB = 32'h0BADF00D;
    @(negedge clk);
    chk("lit_rw_stall", 0, {31'h0, stall_o[0]}, 32'h0);
    @(posedge clk); #1;
    idle();
    ld(32'h34, 2'b10, 0, 32'h0BADF00D, 32'h0BADF00D);

    // store arriving during RD_WAIT is ignored
    in_valid = 1; mem_read = 1; size = 2'b10; addr = 32'h10;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 1; busB = 32'h0;
    @(posedge clk); #1;
    idle();
    ld(32'h10, 2'b10, 0, 32'hDEADBEEF, 32'hDEADBEEF);

    // reset while in RD_WAIT
    in_valid = 1; mem_read = 1; size = 2'b10; addr = 32'h20;
    @(posedge clk); #1;
    idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("lit_rstld_rv", 0, {31'h0, rv_o[0]}, 32'h0);
    chk("lit_rstld_dm", 0, dm_o[0], 32'h0);
    chk("lit_rstld_stall", 0, {31'h0, stall_o[0]}, 32'h0);
    @(posedge clk); #1;

    // aliasing: only the 16-word instance wraps 0x40 onto 0x0
    st(32'h40, 2'b10, 32'h5A5A5A5A);
    ld(32'h0, 2'b10, 0, 32'hCAFEF00D, 32'h5A5A5A5A);

    repeat (2) @(posedge clk);
    #1;
    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_bram.md
# mem_stage_bram

Parametrised MEM-stage successor of the single-cycle data-memory stage. Adds a synchronous-read (BRAM-style) data memory of configurable depth, byte/half/word loads and stores with sign/zero extension, store-data forwarding from WB, misalignment detection, and a two-state load FSM. The FSM stalls the upstream pipeline for exactly one cycle per load. Sits between the EX/MEM and MEM/WB pipeline registers.

## Interface
- ADDR_W, 10, word-index bits; memory holds 2**ADDR_W 32-bit words.
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  MEM-stage instruction valid.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- load_unsigned  in  1  zero-extend load (lbu/lhu) when 1; sign-extend when 0.
- addr  in  32  byte address; bits [ADDR_W+1:0] are used, upper bits are ignored (aliasing).
- busB  in  32  store data from EX/MEM.
- ForwardD  in  1  when 1, store data is taken from C4 instead of busB.
- C4  in  32  WB-stage forwarded value.
- stall  out  1  hold EX/MEM and earlier stages (combinational).
- rdata_valid  out  1  load result valid this cycle.
- dm_rdata  out  32  extended load result.
- misalign  out  1  access dropped because it is misaligned (combinational).

## Operation
- Effective store data: wd = ForwardD ? C4 : busB.
- Aligned access rules:
  - byte: always aligned.
  - half: addr[0]==0.
  - word: addr[1:0]==0.
- misalign = in_valid & (mem_read|mem_write) & !aligned & state==IDLE. A misaligned access performs no read and no write, and does not stall.
- Store, in IDLE with in_valid & mem_write & aligned. Memory is written at the clock edge, word index addr[ADDR_W+1:2].
  - byte: lane addr[1:0] gets wd[7:0]; other lanes unchanged.
  - half: lanes {addr[1],0}+1..0 get wd[15:0].
  - word: all lanes get wd.
  - No stall.
- mem_read & mem_write together: the store is performed and the read is ignored.
- Load FSM states:
  - IDLE: on in_valid & mem_read & !mem_write & aligned, assert stall, register the word index, offset addr[1:0], size and load_unsigned, and go to RD_WAIT.
  - RD_WAIT: memory output is available. stall=0, rdata_valid=1. Inputs are ignored; the held load is not re-issued. Go to IDLE unconditionally.
- Load extraction from the read word w and the registered offset:
  - byte: w[8*off+7 : 8*off], extended to 32 bits.
  - half: w[16*off[1]+15 : 16*off[1]], extended to 32 bits.
  - word: w unchanged.
- dm_rdata holds its last value outside RD_WAIT.
- The memory array is not reset; its contents are undefined after power-up.

## Timing
- Reset values: state=IDLE, rdata_valid=0, dm_rdata=0, stall=0, misalign=0.
- Store latency: data is readable by a load issued on the next cycle (no read-during-write hazard across cycles).
- Load latency: 2 cycles, with 1 stall cycle.
  - Cycle N: load presented, stall=1.
  - Cycle N+1: rdata_valid=1, dm_rdata valid, stall=0. The instruction advances at the end of N+1.
- Back-to-back loads: the second load is presented in N+2 and stalls in N+2.
- A store presented while state==RD_WAIT is impossible, because upstream is held; if one occurs, it is ignored.
- rst asserted in RD_WAIT: next cycle state=IDLE, rdata_valid=0, dm_rdata=0, no pending load. rst has priority over all writes.

## Test plan
- Word round trip: sw 0xDEADBEEF to 0x10, then lw 0x10 -> stall=1 for one cycle, next cycle rdata_valid=1, dm_rdata=0xDEADBEEF.
- Byte lanes and sign extension:
  - Stimulus: sw 0 to 0x20, then sb 0x11,0x22,0x80,0x44 to 0x20..0x23.
  - lw 0x20 -> 0x44802211.
  - lb 0x22 -> 0xFFFFFF80.
  - lbu 0x22 -> 0x00000080.
- Forwarding: busB=0x1, C4=0xCAFEF00D, ForwardD=1, sw to 0x0; lw 0x0 -> 0xCAFEF00D.
- Misalignment:
  - lh 0x31 -> misalign=1, stall=0, no rdata_valid.
  - sw 0x32 with 0xFFFFFFFF -> misalign=1; lw 0x30 afterwards returns the previous contents.
- Reset mid-load: issue lw, assert rst in RD_WAIT -> next cycle rdata_valid=0, dm_rdata=0, stall=0.
- Aliasing with ADDR_W=4: sw 0x5A5A5A5A to 0x40, then lw 0x0 -> 0x5A5A5A5A.
